// File: rtl/capture_sequencer.sv
// Purpose: sequences one ADC capture burst into the single-port sample SRAM, then hands the SRAM port to the serial readout.
// Latency: each accepted adc_newdata strobe appears as an SRAM write exactly 1 clk later; ram_full rises 1 clk after the last write.
// Backpressure: none; the writer always owns the SRAM port while busy, and readout collisions are flagged in overrun.
//
// Ports:
//   clk, rst            system clock, asynchronous active-low reset
//   arm, abort          capture request (rising edge), synchronous level abort
//   cap_len             samples to store minus one, latched on accepted arm
//   adc_newdata/data    ADC sample strobe and sample
//   rd_active/rd_addr   serial readout request for the SRAM port
//   adc_en              enable to the ADC host
//   sram_wen/addr/wdata single-port SRAM interface (write or readout address)
//   ram_full, busy      capture complete / capture in progress
//   wr_count            samples stored in current or last burst
//   overrun             sticky: readout attempted while capturing
module capture_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int DISCARD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cap_len,
  input  logic              adc_newdata,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              rd_active,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              adc_en,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              ram_full,
  output logic              busy,
  output logic [ADDR_W:0]   wr_count,
  output logic              overrun
);

  localparam int DCW = (DISCARD > 1) ? $clog2(DISCARD) : 1;
  localparam logic [DCW-1:0] DLAST = DCW'((DISCARD > 0) ? DISCARD - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, FULL} state_t;

  state_t            state;
  logic              arm_q;
  logic              arm_pending;
  logic              wen_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DCW-1:0]    disc_cnt;
  logic [ADDR_W-1:0] wr_ptr;
  logic              arm_edge;
  logic              accept;

  // The write pointer is cleared and advanced together with wr_count, so the
  // low bits of the count are the next write address. The extra count bit
  // lets a full-depth burst report 2^ADDR_W without the address wrapping.
  assign wr_ptr   = wr_count[ADDR_W-1:0];
  assign arm_edge = arm & ~arm_q;
  assign accept   = ((state == IDLE) || (state == FULL)) && !rd_active &&
                    (arm_edge || arm_pending);

  assign busy       = (state == SETTLE) || (state == CAPTURE);
  assign sram_wen   = wen_q;
  assign sram_wdata = wdata_q;

  // Writer owns the port while capturing or while its last write is in flight
  // (that write is presented in the first FULL cycle).
  always_comb begin
    sram_addr = rd_addr;
    if (wen_q)
      sram_addr = waddr_q;
    else if (busy)
      sram_addr = wr_ptr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      arm_q       <= 1'b0;
      arm_pending <= 1'b0;
      wen_q       <= 1'b0;
      len_q       <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      disc_cnt    <= '0;
      adc_en      <= 1'b0;
      ram_full    <= 1'b0;
      wr_count    <= '0;
      overrun     <= 1'b0;
    end else begin
      arm_q <= arm;
      wen_q <= 1'b0;
      if (abort) begin
        // Dropping wen_q here suppresses the write a coincident strobe
        // would have scheduled; wr_count is left as the partial count.
        state       <= IDLE;
        adc_en      <= 1'b0;
        ram_full    <= 1'b0;
        arm_pending <= 1'b0;
      end else begin
        if (busy && rd_active)
          overrun <= 1'b1;
        case (state)
          IDLE, FULL: begin
            if (state == FULL)
              ram_full <= 1'b1;
            if (accept) begin
              len_q       <= cap_len;
              wr_count    <= '0;
              overrun     <= 1'b0;
              ram_full    <= 1'b0;
              adc_en      <= 1'b1;
              arm_pending <= 1'b0;
              disc_cnt    <= '0;
              state       <= (DISCARD == 0) ? CAPTURE : SETTLE;
            end else if (arm_edge) begin
              // Only reachable with rd_active high: defer until readout ends.
              arm_pending <= 1'b1;
            end
          end
          SETTLE: begin
            if (adc_newdata) begin
              if (disc_cnt == DLAST)
                state <= CAPTURE;
              else
                disc_cnt <= disc_cnt + 1'b1;
            end
          end
          CAPTURE: begin
            if (adc_newdata) begin
              wen_q    <= 1'b1;
              waddr_q  <= wr_ptr;
              wdata_q  <= adc_data;
              wr_count <= wr_count + 1'b1;
              if (wr_ptr == len_q) begin
                adc_en <= 1'b0;
                state  <= FULL;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_sequencer.sv
module tb_capture_sequencer;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          adc_newdata = 1'b0;
  logic          rd_active = 1'b0;
  logic [AW-1:0] cap_len = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] adc_data = '0;

  logic          en4, wen4, full4, busy4, ovr4;
  logic [AW-1:0] addr4;
  logic [DW-1:0] wd4;
  logic [AW:0]   cnt4;
  logic          en0, wen0, full0, busy0, ovr0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wd0;
  logic [AW:0]   cnt0;

  capture_sequencer #(.ADDR_W(AW), .DATA_W(DW), .DISCARD(4)) u_d4 (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .cap_len(cap_len),
    .adc_newdata(adc_newdata), .adc_data(adc_data), .rd_active(rd_active),
    .rd_addr(rd_addr), .adc_en(en4), .sram_wen(wen4), .sram_addr(addr4),
    .sram_wdata(wd4), .ram_full(full4), .busy(busy4), .wr_count(cnt4),
    .overrun(ovr4));

  capture_sequencer #(.ADDR_W(AW), .DATA_W(DW), .DISCARD(0)) u_d0 (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .cap_len(cap_len),
    .adc_newdata(adc_newdata), .adc_data(adc_data), .rd_active(rd_active),
    .rd_addr(rd_addr), .adc_en(en0), .sram_wen(wen0), .sram_addr(addr0),
    .sram_wdata(wd0), .ram_full(full0), .busy(busy0), .wr_count(cnt0),
    .overrun(ovr0));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t wq4[$];
  wr_t wq0[$];
  wr_t sq[$];

  always @(negedge clk) begin
    if (wen4 === 1'b1) wq4.push_back(wr_t'{cyc, addr4, wd4});
    if (wen0 === 1'b1) wq0.push_back(wr_t'{cyc, addr0, wd0});
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [DW-1:0] d);
    adc_newdata = 1'b1;
    adc_data    = d;
    sq.push_back(wr_t'{cyc, '0, d});
    tick();
    adc_newdata = 1'b0;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Reference model: strobe k (counted from the accepted arm) is dropped for
  // k < disc, stored at address k-disc for disc <= k <= disc+len, ignored
  // afterwards; every stored sample is seen on the SRAM port one cycle later.
  task automatic check_burst(input string tag, input int which, input int disc, input int len);
    wr_t a[$];
    if (which == 4) a = wq4;
    else            a = wq0;
    chk({tag, "_nwrites"}, a.size(), len + 1);
    for (int i = 0; i <= len && i < a.size(); i++) begin
      wr_t s;
      s = sq[disc + i];
      checks++;
      assert (a[i].cyc === s.cyc + 1 && a[i].addr === AW'(i) && a[i].data === s.data) else begin
        errors++;
        $error("FAIL %s_write%0d observed cyc=%0d addr=%0h data=%0h expected cyc=%0d addr=%0h data=%0h",
               tag, i, a[i].cyc, a[i].addr, a[i].data, s.cyc + 1, i, s.data);
      end
    end
  endtask

  initial begin
    int n_before;

    // Reset state
    repeat (3) tick();
    chk("rst_adc_en", {en4, en0}, 2'b00);
    chk("rst_wen", {wen4, wen0}, 2'b00);
    chk("rst_wdata", {wd4, wd0}, 32'h0);
    chk("rst_full", {full4, full0}, 2'b00);
    chk("rst_busy", {busy4, busy0}, 2'b00);
    chk("rst_count", {cnt4, cnt0}, 34'h0);
    chk("rst_overrun", {ovr4, ovr0}, 2'b00);
    rst = 1'b1;
    repeat (2) tick();

    // Basic burst with settle discard, random strobe spacing
    cap_len = 16'd7;
    arm_pulse();
    chk("b1_busy", busy4, 1'b1);
    chk("b1_adc_en", en4, 1'b1);
    tick();
    for (int n = 0; n < 15; n++) begin
      strobe(16'h1000 + 16'(n));
      repeat ($urandom_range(0, 2)) tick();
    end
    repeat (3) tick();
    check_burst("b1_d4", 4, 4, 7);
    check_burst("b1_d0", 0, 0, 7);
    chk("b1_full", full4, 1'b1);
    chk("b1_en_off", en4, 1'b0);
    chk("b1_count", cnt4, 17'd8);
    chk("b1_idle", busy4, 1'b0);
    chk("b1_d0_count", cnt0, 17'd8);

    // Back-to-back strobes into the no-discard instance
    wq0.delete();
    sq.delete();
    cap_len = 16'd3;
    arm_pulse();
    for (int n = 0; n < 4; n++) strobe(16'($urandom));
    chk("b2_last_wen", wen0, 1'b1);
    chk("b2_full_not_yet", full0, 1'b0);
    tick();
    chk("b2_full", full0, 1'b1);
    chk("b2_wen_off", wen0, 1'b0);
    check_burst("b2", 0, 0, 3);

    // Arm while readout owns the SRAM: deferred until rd_active drops
    rd_active = 1'b1;
    rd_addr   = 16'h1234;
    cap_len   = 16'd5;
    arm_pulse();
    chk("b3_hold_full", full0, 1'b1);
    chk("b3_hold_busy", busy0, 1'b0);
    chk("b3_rd_addr", addr0, 16'h1234);
    rd_addr = 16'h0042;
    repeat (2) tick();
    chk("b3_rd_track", addr0, 16'h0042);
    chk("b3_no_wen", wen0, 1'b0);
    rd_active = 1'b0;
    tick();
    chk("b3_start", busy0, 1'b1);
    chk("b3_full_clr", full0, 1'b0);
    chk("b3_en", en0, 1'b1);
    chk("b3_wr_addr", addr0, 16'h0000);

    // Abort coincident with a strobe and an arm edge
    strobe(16'hAAAA);
    strobe(16'hBBBB);
    adc_newdata = 1'b1;
    adc_data    = 16'hCCCC;
    abort       = 1'b1;
    arm         = 1'b1;
    tick();
    adc_newdata = 1'b0;
    abort       = 1'b0;
    chk("b4_wen_supp", wen0, 1'b0);
    chk("b4_idle", busy0, 1'b0);
    chk("b4_en", en0, 1'b0);
    chk("b4_full", full0, 1'b0);
    chk("b4_count_kept", cnt0, 17'd2);
    tick();
    arm = 1'b0;
    tick();
    chk("b4_arm_ignored", busy0, 1'b0);

    // Full depth with a readout collision mid-burst
    wq0.delete();
    sq.delete();
    cap_len = 16'hFFFF;
    arm_pulse();
    for (int n = 0; n < 65536; n++) begin
      rd_active = (n == 30000);
      strobe(16'($urandom));
    end
    rd_active = 1'b0;
    repeat (2) tick();
    check_burst("deep", 0, 0, 65535);
    chk("deep_count", cnt0, 17'h10000);
    chk("deep_full", full0, 1'b1);
    chk("deep_overrun", ovr0, 1'b1);
    repeat (3) tick();
    chk("deep_overrun_sticky", ovr0, 1'b1);

    // Async reset mid-capture
    arm_pulse();
    chk("ar_overrun_clr", ovr0, 1'b0);
    strobe(16'h5A5A);
    chk("ar_wen_before", wen0, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("ar_wen", wen0, 1'b0);
    chk("ar_wdata", wd0, 16'h0);
    chk("ar_en", en0, 1'b0);
    chk("ar_busy", busy0, 1'b0);
    chk("ar_count", cnt0, 17'h0);
    tick();
    rst = 1'b1;
    n_before = wq0.size();
    for (int n = 0; n < 3; n++) strobe(16'h1111);
    tick();
    chk("ar_no_restart", wq0.size(), n_before);
    chk("ar_idle", busy0, 1'b0);
    arm_pulse();
    chk("ar_rearm", busy0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Sequences one ADC capture burst into the single-port 16x16 sample SRAM, then hands the SRAM port to the serial readout.
- Sits between adc_host (newdata/adcdata/enable), the serial readout (address/active), and sram16x16 (wen/addr/wdata).
- Replaces ad-hoc top-level holdoff/ramfull logic with an explicit state machine: programmable capture length, settle discard, abort, and arm-while-reading deferral.

Parameters:
ADDR_W, 16, SRAM address width; maximum capture depth 2^ADDR_W samples
DATA_W, 16, sample width
DISCARD, 4, newdata pulses dropped after arm before storing (ADC settle); 0 allowed

Ports:
clk  in  1  system clock (PLL clock domain)
rst  in  1  asynchronous, active-low reset
arm  in  1  capture request; rising edge detected internally
abort  in  1  synchronous abort, level, checked every cycle
cap_len  in  ADDR_W  samples to store minus one; latched on accepted arm
adc_newdata  in  1  one-cycle strobe from ADC host: adc_data valid
adc_data  in  DATA_W  ADC sample
rd_active  in  1  readout currently using SRAM
rd_addr  in  ADDR_W  readout address
adc_en  out  1  enable to ADC host
sram_wen  out  1  SRAM write enable
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  DATA_W  SRAM write data
ram_full  out  1  capture complete, data valid for readout
busy  out  1  high in SETTLE or CAPTURE
wr_count  out  ADDR_W+1  samples stored in current/last burst
overrun  out  1  sticky: rd_active seen high during SETTLE/CAPTURE; cleared on accepted arm

Behaviour:
- Reset (rst=0, async): state IDLE; adc_en=0, sram_wen=0, sram_wdata=0, ram_full=0, wr_count=0, overrun=0, arm pipeline=0, arm_pending=0, write pointer=0.
- States: IDLE, SETTLE, CAPTURE, FULL.
- arm edge = arm & ~arm_q (arm_q registered). Edge is ignored in SETTLE/CAPTURE.
- Edge in IDLE/FULL with rd_active=0 is accepted. Edge with rd_active=1 sets arm_pending instead; arm_pending is accepted on the first cycle rd_active=0.
- On accept: latch cap_len to len_q; clear wr_ptr, wr_count and overrun; ram_full<=0; adc_en<=1.
- After accept, next state is SETTLE, or CAPTURE directly if DISCARD=0.
- SETTLE: count adc_newdata pulses; after the DISCARD-th pulse go to CAPTURE. Discarded samples are never written.
- CAPTURE write path, for each adc_newdata:
  - The next cycle presents sram_wen=1, sram_addr=wr_ptr, sram_wdata=adc_data registered at the strobe.
  - Write latency is exactly 1 clk. Strobes on consecutive cycles are each written.
  - wr_ptr and wr_count increment with each write.
- Completion: when the write with wr_ptr==len_q is issued, that write completes. In the same cycle: adc_en<=0, state<=FULL; ram_full=1 the following cycle. Strobes after that point are ignored.
- cap_len = all ones stores 2^ADDR_W samples; wr_count reaches 2^ADDR_W; wr_ptr never wraps.
- SRAM port mux (combinational from registered state):
  - In SETTLE, CAPTURE, or while a write is in flight: sram_addr = write address.
  - Otherwise: sram_addr = rd_addr, sram_wen=0.
- The writer always has priority. If rd_active=1 during SETTLE/CAPTURE, overrun<=1 and reader data is undefined.
- FULL: hold ram_full=1, adc_en=0 until the next accepted arm or abort.
- abort=1 in any state, next cycle:
  - state IDLE; adc_en=0, ram_full=0, arm_pending=0.
  - Any write scheduled for that cycle is suppressed (sram_wen=0).
  - wr_count keeps its value.
  - abort has priority over a simultaneous arm edge.
- Async reset mid-capture: immediate return to reset values; SRAM contents are not cleared.
- busy = (state==SETTLE)|(state==CAPTURE).

Test Plan:
- Basic burst: DISCARD=4, cap_len=7, arm pulse, 12 newdata strobes with data 0x1000+n -> writes 0x1004..0x100B to addr 0..7, each 1 clk after its strobe; then ram_full=1, adc_en=0, wr_count=8; strobes 13+ produce no wen.
- Back-to-back strobes: DISCARD=0, cap_len=3, newdata on 4 consecutive cycles -> 4 consecutive wen cycles at addr 0,1,2,3; FULL 1 clk after the last write.
- Arm during readout: ram_full=1, rd_active=1, arm edge -> no state change, sram_addr tracks rd_addr; drop rd_active -> capture starts next cycle, ram_full=0.
- Abort: abort mid-CAPTURE coincident with a pending write -> sram_wen=0 that cycle, state IDLE, adc_en=0, ram_full=0; simultaneous arm edge ignored.
- Full depth: cap_len=0xFFFF, DISCARD=0, 65536 strobes -> last write at addr 0xFFFF, wr_count=0x10000, no write to addr 0; overrun pulse on rd_active mid-burst -> overrun=1 until next arm.
- Async reset: rst low mid-CAPTURE between clock edges -> all outputs at reset values immediately; release -> IDLE, arm required to restart.
